// File: rtl/edge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : edge_pkg
//  Purpose  : Shared definitions for the edge-handling blocks. This package
//             holds the level FSM state encoding, the request-decode
//             encoding and the decode helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package edge_pkg;

  // Level FSM. The MSB equals the level that the state represents.
  typedef enum logic [1:0] {
    LO_IDLE = 2'd0,
    LO_HOLD = 2'd1,
    HI_IDLE = 2'd2,
    HI_HOLD = 2'd3
  } edge_state_e;

  // Operation applied to the target register.
  localparam logic [1:0] REQ_NONE = 2'd0;
  localparam logic [1:0] REQ_SET  = 2'd1;
  localparam logic [1:0] REQ_CLR  = 2'd2;
  localparam logic [1:0] REQ_TOG  = 2'd3;

  typedef struct packed {
    logic       conflict;  // some request bits were discarded this cycle
    logic [1:0] op;        // operation that survives the decode
  } edge_req_t;

  // p+n together cancel everything. t with a single p or n loses to p/n.
  // Both cases are reported as a conflict.
  function automatic edge_req_t decode_req(input logic p, input logic n,
                                           input logic t);
    edge_req_t r;
    r.conflict = 1'b0;
    r.op       = REQ_NONE;
    if (p && n) begin
      r.conflict = 1'b1;
    end else if (p) begin
      r.op       = REQ_SET;
      r.conflict = t;
    end else if (n) begin
      r.op       = REQ_CLR;
      r.conflict = t;
    end else if (t) begin
      r.op       = REQ_TOG;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_to_level_hold_counter.sv
`default_nettype none
// ============================================================================
//  Module   : hold_counter
//  Purpose  : Load/decrement down-counter. It holds at zero and provides a
//             zero flag.
//  Ports    : clk, reset_n (async, active-low)
//             load, load_val[CW-1:0] : load takes priority over decrement
//             count[CW-1:0], zero    : current value, value == 0
//  Revision : 1.0 - initial release
// ============================================================================
module hold_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] count,
  output logic          zero
);

  localparam logic [CW-1:0] c_one = CW'(1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - c_one;
    end
  end

  assign count = r_count;
  assign zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/edge_to_level.sv
`default_nettype none
// ============================================================================
//  Module   : edge_to_level
//  Purpose  : Rebuilds a registered level from single-cycle rise/fall/toggle
//             requests. Each level is held for at least MIN_HOLD cycles.
//             Requests that arrive during a hold are folded into a target bit
//             and applied when the hold expires.
//  Ports    : clk, reset_n (async, active-low)
//             p_edge / n_edge / t_edge : set / clear / toggle requests
//             level     : reconstructed level (registered)
//             rise/fall : one-cycle pulses in the first cycle of a new level
//             busy      : hold counter nonzero
//             pending   : target differs from level
//             drop      : conflicting request discarded last cycle
//             err       : redundant request seen last cycle
//                         (present only with EDGE_TO_LEVEL_ERR_EN)
//  Macro    : EDGE_TO_LEVEL_ERR_EN adds the err port and its logic.
//  Revision : 1.0 - initial release
// ============================================================================
module edge_to_level
  import edge_pkg::*;
#(
  parameter int   MIN_HOLD   = 4,
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic p_edge,
  input  logic n_edge,
  input  logic t_edge,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy,
  output logic pending,
`ifdef EDGE_TO_LEVEL_ERR_EN
  output logic drop,
  output logic err
`else
  output logic drop
`endif
);

  localparam int              CW            = $clog2(MIN_HOLD + 1);
  localparam logic [CW-1:0]   c_hold_load   = CW'(MIN_HOLD - 1);
  localparam edge_state_e     c_reset_state = INIT_LEVEL ? HI_IDLE : LO_IDLE;

  edge_state_e   r_state;
  edge_state_e   w_state_nxt;
  logic          r_target;
  logic          r_level;
  logic          r_rise;
  logic          r_fall;
  logic          r_drop;
  edge_req_t     w_req;
  logic          w_target_nxt;
  logic          w_idle;
  logic          w_can_change;
  logic          w_flip;
  logic [CW-1:0] w_count;
  logic          w_zero;

  assign w_req = decode_req(p_edge, n_edge, t_edge);

  // The target follows requests every cycle, even during a hold. As a
  // result, a later request can cancel a deferred change.
  always_comb begin
    w_target_nxt = r_target;
    case (w_req.op)
      REQ_SET: w_target_nxt = 1'b1;
      REQ_CLR: w_target_nxt = 1'b0;
      REQ_TOG: w_target_nxt = ~r_target;
      default: w_target_nxt = r_target;
    endcase
  end

  // A hold that has counted down to zero behaves like IDLE. This lets a
  // deferred change land in the cycle right after the counter reaches zero.
  assign w_idle       = (r_state == LO_IDLE) || (r_state == HI_IDLE);
  assign w_can_change = w_idle || w_zero;
  assign w_flip       = w_can_change && (w_target_nxt != r_level);

  always_comb begin
    w_state_nxt = r_state;
    if (w_flip) begin
      w_state_nxt = r_level ? LO_HOLD : HI_HOLD;
    end else if (w_can_change) begin
      w_state_nxt = r_level ? HI_IDLE : LO_IDLE;
    end
  end

  hold_counter #(
    .CW (CW)
  ) u_hold_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (w_flip),
    .load_val (c_hold_load),
    .count    (w_count),
    .zero     (w_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= c_reset_state;
      r_target <= INIT_LEVEL;
      r_level  <= INIT_LEVEL;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_target <= w_target_nxt;
      r_drop   <= w_req.conflict;
      r_rise   <= w_flip && !r_level;
      r_fall   <= w_flip && r_level;
      if (w_flip) begin
        r_level <= ~r_level;
      end
    end
  end

`ifdef EDGE_TO_LEVEL_ERR_EN
  logic r_err;

  // A request is redundant when it asks for the value the target already
  // holds. Requests that were flagged as conflicts are excluded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= !w_req.conflict &&
               (((w_req.op == REQ_SET) && r_target) ||
                ((w_req.op == REQ_CLR) && !r_target));
    end
  end

  assign err = r_err;
`endif

  assign level   = r_level;
  assign rise    = r_rise;
  assign fall    = r_fall;
  assign drop    = r_drop;
  assign busy    = !w_zero;
  assign pending = (r_target != r_level);

endmodule
`default_nettype wire

// File: tb/tb_edge_to_level.sv
`default_nettype none
// ============================================================================
//  Module   : tb_edge_to_level
//  Purpose  : Self-checking bench for edge_to_level. It drives two instances
//             (MIN_HOLD=4 and MIN_HOLD=1) with the same request stream and
//             compares both against a timestamp-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_edge_to_level;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic p_edge  = 1'b0;
  logic n_edge  = 1'b0;
  logic t_edge  = 1'b0;

  logic [1:0] d_level, d_rise, d_fall, d_busy, d_pending, d_drop;
`ifdef EDGE_TO_LEVEL_ERR_EN
  logic [1:0] d_err;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  edge_to_level #(.MIN_HOLD(4), .INIT_LEVEL(1'b0)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .p_edge(p_edge), .n_edge(n_edge),
    .t_edge(t_edge), .level(d_level[0]), .rise(d_rise[0]), .fall(d_fall[0]),
    .busy(d_busy[0]), .pending(d_pending[0]),
`ifdef EDGE_TO_LEVEL_ERR_EN
    .drop(d_drop[0]), .err(d_err[0])
`else
    .drop(d_drop[0])
`endif
  );

  edge_to_level #(.MIN_HOLD(1), .INIT_LEVEL(1'b0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .p_edge(p_edge), .n_edge(n_edge),
    .t_edge(t_edge), .level(d_level[1]), .rise(d_rise[1]), .fall(d_fall[1]),
    .busy(d_busy[1]), .pending(d_pending[1]),
`ifdef EDGE_TO_LEVEL_ERR_EN
    .drop(d_drop[1]), .err(d_err[1])
`else
    .drop(d_drop[1])
`endif
  );

  // ---------------------------------------------------------------------
  // Reference model. It records the cycle index of the last level change.
  // A new change is allowed once at least HOLD cycles have passed since
  // then. busy is true while fewer than HOLD-1 cycles have elapsed.
  // ---------------------------------------------------------------------
  int   hold [2] = '{4, 1};
  int   cyc = 0;
  int   m_last   [2] = '{-1000, -1000};
  logic m_target [2] = '{1'b0, 1'b0};
  logic m_level  [2] = '{1'b0, 1'b0};
  logic m_rise   [2] = '{1'b0, 1'b0};
  logic m_fall   [2] = '{1'b0, 1'b0};
  logic m_drop   [2] = '{1'b0, 1'b0};
  logic m_err    [2] = '{1'b0, 1'b0};
  logic m_conf, m_tn;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        m_target[i] = 1'b0; m_level[i] = 1'b0; m_last[i] = -1000;
        m_rise[i] = 1'b0; m_fall[i] = 1'b0; m_drop[i] = 1'b0; m_err[i] = 1'b0;
      end
    end else begin
      cyc = cyc + 1;
      for (int i = 0; i < 2; i++) begin
        m_conf = (p_edge && n_edge) || (t_edge && (p_edge != n_edge));
        m_err[i] = !m_conf && ((p_edge && m_target[i]) || (n_edge && !m_target[i]));
        m_tn = m_target[i];
        if (p_edge && n_edge) m_tn = m_target[i];
        else if (p_edge)      m_tn = 1'b1;
        else if (n_edge)      m_tn = 1'b0;
        else if (t_edge)      m_tn = !m_target[i];
        m_target[i] = m_tn;
        m_drop[i]   = m_conf;
        m_rise[i]   = 1'b0;
        m_fall[i]   = 1'b0;
        if ((m_tn != m_level[i]) && (cyc - m_last[i] >= hold[i])) begin
          m_level[i] = m_tn;
          m_last[i]  = cyc;
          m_rise[i]  = m_tn;
          m_fall[i]  = !m_tn;
        end
      end
    end
  end

  function automatic logic exp_busy(input int i);
    return (cyc - m_last[i]) < (hold[i] - 1);
  endfunction

  task automatic chk(input string nm, input logic act, input logic exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Literal expectations check both the DUT and the model.
  task automatic lit(input string nm, input logic dut_v, input logic mod_v,
                     input logic exp);
    chk({nm, " dut"}, dut_v, exp);
    chk({nm, " model"}, mod_v, exp);
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("level[%0d]", i),   d_level[i],   m_level[i]);
        chk($sformatf("rise[%0d]", i),    d_rise[i],    m_rise[i]);
        chk($sformatf("fall[%0d]", i),    d_fall[i],    m_fall[i]);
        chk($sformatf("busy[%0d]", i),    d_busy[i],    exp_busy(i));
        chk($sformatf("pending[%0d]", i), d_pending[i], m_target[i] != m_level[i]);
        chk($sformatf("drop[%0d]", i),    d_drop[i],    m_drop[i]);
`ifdef EDGE_TO_LEVEL_ERR_EN
        chk($sformatf("err[%0d]", i),     d_err[i],     m_err[i]);
`endif
      end
    end
  end

  // Each call occupies one cycle. The inputs are applied just after the
  // falling edge, and the outputs read right after return belong to the
  // same cycle.
  task automatic step(input logic p, input logic n, input logic t);
    @(negedge clk);
    #1;
    p_edge = p; n_edge = n; t_edge = t;
  endtask

  // After return, the next rising edge starts cycle 0.
  task automatic do_reset();
    @(negedge clk);
    #1;
    reset_n = 1'b0; p_edge = 1'b0; n_edge = 1'b0; t_edge = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;

    // Reset state, then a rise and its hold window.
    do_reset();
    step(0, 0, 0);
    lit("rst level",   d_level[0],   m_level[0],   1'b0);
    lit("rst rise",    d_rise[0],    m_rise[0],    1'b0);
    lit("rst fall",    d_fall[0],    m_fall[0],    1'b0);
    lit("rst busy",    d_busy[0],    exp_busy(0),  1'b0);
    lit("rst pending", d_pending[0], m_target[0] != m_level[0], 1'b0);
    lit("rst drop",    d_drop[0],    m_drop[0],    1'b0);
    step(0, 0, 0);
    step(1, 0, 0);                                   // c2
    step(0, 0, 0);                                   // c3
    lit("rise c3 level", d_level[0], m_level[0], 1'b1);
    lit("rise c3 rise",  d_rise[0],  m_rise[0],  1'b1);
    lit("rise c3 busy",  d_busy[0],  exp_busy(0), 1'b1);
    step(0, 0, 0);                                   // c4
    lit("rise c4 busy",  d_busy[0],  exp_busy(0), 1'b1);
    lit("rise c4 rise",  d_rise[0],  m_rise[0],  1'b0);
    step(0, 0, 0);                                   // c5
    lit("rise c5 busy",  d_busy[0],  exp_busy(0), 1'b1);
    step(0, 0, 0);                                   // c6
    lit("rise c6 busy",  d_busy[0],  exp_busy(0), 1'b0);
    lit("rise c6 level", d_level[0], m_level[0], 1'b1);

    // A deferred fall.
    do_reset();
    step(0, 0, 0); step(0, 0, 0);
    step(1, 0, 0);                                   // c2
    step(0, 0, 0);                                   // c3
    step(0, 1, 0);                                   // c4
    step(0, 0, 0);                                   // c5
    lit("defer c5 pending", d_pending[0], m_target[0] != m_level[0], 1'b1);
    lit("defer c5 level",   d_level[0],   m_level[0], 1'b1);
    step(0, 0, 0);                                   // c6
    lit("defer c6 pending", d_pending[0], m_target[0] != m_level[0], 1'b1);
    step(0, 0, 0);                                   // c7
    lit("defer c7 level", d_level[0], m_level[0], 1'b0);
    lit("defer c7 fall",  d_fall[0],  m_fall[0],  1'b1);

    // A deferred change cancelled by a later request.
    do_reset();
    step(0, 0, 0); step(0, 0, 0);
    step(1, 0, 0);                                   // c2
    step(0, 0, 0);                                   // c3
    step(0, 1, 0);                                   // c4
    step(1, 0, 0);                                   // c5
    lit("cancel c5 pending", d_pending[0], m_target[0] != m_level[0], 1'b1);
    lit("cancel c5 drop",    d_drop[0],    m_drop[0], 1'b0);
    step(0, 0, 0);                                   // c6
    lit("cancel c6 pending", d_pending[0], m_target[0] != m_level[0], 1'b0);
    step(0, 0, 0);                                   // c7
    lit("cancel c7 level", d_level[0], m_level[0], 1'b1);
    lit("cancel c7 fall",  d_fall[0],  m_fall[0],  1'b0);
    lit("cancel c7 drop",  d_drop[0],  m_drop[0],  1'b0);

    // Conflicting requests.
    do_reset();
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    step(1, 1, 0);                                   // c3
    step(0, 0, 0);                                   // c4
    lit("pn c4 drop",    d_drop[0],    m_drop[0],  1'b1);
    lit("pn c4 level",   d_level[0],   m_level[0], 1'b0);
    lit("pn c4 pending", d_pending[0], m_target[0] != m_level[0], 1'b0);
    step(1, 0, 0);                                   // c5
    step(0, 0, 0);                                   // c6
    lit("tn c6 level", d_level[0], m_level[0], 1'b1);
    step(0, 0, 0); step(0, 0, 0);                    // c7, c8
    step(0, 1, 1);                                   // c9
    step(0, 0, 0);                                   // c10
    lit("tn c10 level", d_level[0], m_level[0], 1'b0);
    lit("tn c10 fall",  d_fall[0],  m_fall[0],  1'b1);
    lit("tn c10 drop",  d_drop[0],  m_drop[0],  1'b1);

    // Toggle every cycle. MIN_HOLD=1 follows each toggle.
    do_reset();
    step(0, 0, 1);                                   // c0
    for (int k = 1; k <= 7; k++) begin
      step(0, 0, 1);
      lit($sformatf("tog c%0d level", k), d_level[1], m_level[1], logic'(k % 2));
      lit($sformatf("tog c%0d rise", k),  d_rise[1],  m_rise[1],  logic'(k % 2));
      lit($sformatf("tog c%0d fall", k),  d_fall[1],  m_fall[1],  logic'((k + 1) % 2));
      lit($sformatf("tog c%0d busy", k),  d_busy[1],  exp_busy(1), 1'b0);
    end
    step(0, 0, 0);

    // Reset during HI_HOLD while a change is pending.
    do_reset();
    step(0, 0, 0); step(0, 0, 0);
    step(1, 0, 0);                                   // c2
    step(0, 1, 0);                                   // c3
    step(0, 0, 0);                                   // c4
    lit("mid c4 pending", d_pending[0], m_target[0] != m_level[0], 1'b1);
    lit("mid c4 level",   d_level[0],   m_level[0], 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    lit("mid rst level",   d_level[0],   m_level[0], 1'b0);
    lit("mid rst pending", d_pending[0], m_target[0] != m_level[0], 1'b0);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 0);
      lit($sformatf("post c%0d fall", k),  d_fall[0],  m_fall[0],  1'b0);
      lit($sformatf("post c%0d level", k), d_level[0], m_level[0], 1'b0);
    end

`ifdef EDGE_TO_LEVEL_ERR_EN
    // Redundant requests.
    do_reset();
    step(0, 1, 0);                                   // c0: n while target=0
    step(0, 0, 0);                                   // c1
    lit("err c1", d_err[0], m_err[0], 1'b1);
    step(1, 0, 0);                                   // c2
    step(1, 0, 0);                                   // c3
    lit("err c3", d_err[0], m_err[0], 1'b0);
    step(0, 0, 0);                                   // c4
    lit("err c4", d_err[0], m_err[0], 1'b1);
    step(0, 0, 0);
`endif

    step(0, 0, 0);
    step(0, 0, 0);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/edge_to_level.md
# edge_to_level

Reconstructs a clean registered level from a stream of single-cycle edge events (rise, fall, toggle) and enforces a minimum hold time on every level. Sits downstream of the team's edge detectors and at the far end of event links, where it rebuilds the original signal. Opposite requests that arrive during a hold are deferred, not lost. The block also regenerates aligned rise/fall pulses for local consumers.

## Interface
Parameters:
- MIN_HOLD, 4: minimum cycles each level is held after a change; legal range ≥1.
- INIT_LEVEL, 0: value of level, and of the target register, on reset.
- CW, derived as $clog2(MIN_HOLD+1): hold counter width. Not overridable.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  reset; asynchronous, active-low. Clock is clk.
- p_edge  in  1  one-cycle request to drive level high.
- n_edge  in  1  one-cycle request to drive level low.
- t_edge  in  1  one-cycle request to invert the current target.
- level  out  1  reconstructed level, registered.
- rise  out  1  high for one cycle in the first cycle level=1.
- fall  out  1  high for one cycle in the first cycle level=0.
- busy  out  1  hold counter nonzero; level may not change next cycle.
- pending  out  1  target≠level; a deferred change is queued.
- drop  out  1  one-cycle pulse, the cycle after a conflicting request was discarded.
- err  out  1  present only with EDGE_TO_LEVEL_ERR_EN; see Configuration.

## Operation
- Internal state: target bit, level bit, hold counter (CW bits), FSM {LO_IDLE, LO_HOLD, HI_IDLE, HI_HOLD}.
- Request decode, per cycle:
  - p_edge alone sets target to 1.
  - n_edge alone sets target to 0.
  - t_edge alone sets target to ~target.
  - p_edge with n_edge: all requests ignored, drop=1 next cycle.
  - t_edge with exactly one of p_edge/n_edge: p/n wins, t ignored, drop=1 next cycle.
- Target tracking: target updates every cycle from the decoded request, regardless of hold.
  - Consequence: an opposite request followed by a same-level request cancels the deferred change; no drop is flagged.
- IDLE states: if next target≠level, level flips next cycle. The FSM moves to the HOLD state of the new level and loads the counter with MIN_HOLD-1.
- HOLD states: the counter decrements each cycle.
  - At counter=0 the state becomes IDLE.
  - If target≠level at that point (pending, or a same-cycle request), the flip happens next cycle as in IDLE.
- rise/fall are registered alongside level and are never both 1.
- busy = (counter≠0). pending = (target≠level). Both are combinational from registers.
- Reset value, all outputs: level=INIT_LEVEL, target=INIT_LEVEL, FSM in IDLE of INIT_LEVEL, counter=0, rise=fall=drop=err=0.
- Reset mid-hold discards the pending change.

## Timing
- Latency: a request in cycle t changes level at t+1 when not busy.
- After a change at t+1, level holds through t+MIN_HOLD. The earliest next change is t+MIN_HOLD+1.
- MIN_HOLD=1: the counter loads 0, so level may change every cycle.
- A deferred change lands exactly the cycle after the counter reaches 0.

## Configuration
- EDGE_TO_LEVEL_ERR_EN defined:
  - Adds the err port.
  - err pulses one cycle after a redundant request, meaning p_edge while target=1 or n_edge while target=0, excluding requests already counted as drops.
- Macro undefined: the err port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package edge_pkg: FSM state enum (LO_IDLE, LO_HOLD, HI_IDLE, HI_HOLD) and the request-decode encoding constants. Reused by the team's other edge blocks.
- One sub-module, hold_counter: load/decrement down-counter with a zero flag, parameterised by CW.

## Test plan
- Reset, INIT_LEVEL=0, MIN_HOLD=4:
  - Required: level=0 and rise=fall=busy=pending=drop=0.
  - Then p_edge at cycle 2. Required: level=1 and rise=1 at cycle 3; busy=1 for cycles 3–5; level stays 1 through cycle 6.
- Deferred change: p_edge at cycle 2, n_edge at cycle 4.
  - Required: pending=1 for cycles 5–6; level=0 and fall=1 at cycle 7.
- Cancellation: p_edge at 2, n_edge at 4, p_edge at 5.
  - Required: pending=1 at cycle 5 only; level stays 1; no fall; drop=0.
- Conflicts:
  - p_edge and n_edge together at cycle 3. Required: drop=1 at cycle 4; level and target unchanged.
  - t_edge with n_edge at level 1. Required: level falls; drop=1.
- MIN_HOLD=1 with t_edge every cycle.
  - Required: level toggles every cycle; rise and fall alternate; busy=0 throughout.
- Reset mid-operation: assert reset_n=0 during HI_HOLD with pending=1.
  - Required: immediate level=INIT_LEVEL and pending=0; no stale fall after release.
  - With EDGE_TO_LEVEL_ERR_EN: a second p_edge while target=1 gives err=1 one cycle later.
